// File: rtl/div_seq_16x8.sv
// Sequential restoring divider: unsigned DIVIDEND_W / DIVISOR_W, one quotient
// bit per clock. Used to recover a multiplier operand from a product (P / A -> B)
// when characterising the approximate multipliers.
//
// Handshake: a request is taken on a rising edge where in_valid & in_ready; a
// result is consumed on a rising edge where out_valid & out_ready. in_ready is
// high only in IDLE and out_valid only in DONE, so a request is never accepted
// on the same edge that a result is consumed.
module div_seq_16x8 #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(DIVIDEND_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Working registers. dq starts as the dividend; each step shifts its MSB
  // into the partial remainder and the new quotient bit into its LSB, so after
  // DIVIDEND_W steps it holds the quotient.
  logic [DIVIDEND_W-1:0] dq;
  logic [DIVISOR_W-1:0]  dvs;
  logic [DIVISOR_W:0]    prem;
  logic [CNT_W-1:0]      cnt;

  logic [DIVISOR_W:0]    shifted;
  logic [DIVISOR_W:0]    prem_nxt;
  logic                  qbit;
  logic                  accept;
  logic                  consume;
  logic                  last_step;

  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;
  assign last_step = (cnt == '0);

  // One restoring step. The partial remainder is one bit wider than the
  // divisor so the compare cannot overflow. With a zero divisor the compare
  // always succeeds and nothing is subtracted, which yields an all-ones
  // quotient and the low dividend bits as the remainder.
  always_comb begin
    shifted  = {prem[DIVISOR_W-1:0], dq[DIVIDEND_W-1]};
    qbit     = (shifted >= {1'b0, dvs});
    prem_nxt = shifted;
    if (qbit) begin
      prem_nxt = shifted - {1'b0, dvs};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE -> RUN -> DONE -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (consume) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: load on accept, iterate in RUN, publish results on the last step.
  // Result registers are only written on the last step so they hold steady
  // through DONE and keep their old values in IDLE and RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq          <= '0;
      dvs         <= '0;
      prem        <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      dq   <= dividend;
      dvs  <= divisor;
      prem <= '0;
      cnt  <= CNT_START;
    end else if (state == RUN) begin
      dq   <= {dq[DIVIDEND_W-2:0], qbit};
      prem <= prem_nxt;
      if (last_step) begin
        quotient    <= {dq[DIVIDEND_W-2:0], qbit};
        remainder   <= prem_nxt[DIVISOR_W-1:0];
        div_by_zero <= (dvs == '0);
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_div_seq_16x8.sv
// Bench for div_seq_16x8: directed vector table, backpressure and mid-run
// reset sequences, and a randomized sweep against an arithmetic reference.
module tb_div_seq_16x8;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
  } vec_t;

  vec_t vecs[$];

  div_seq_16x8 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer division; a zero divisor gives all-ones and the
  // low dividend byte.
  task automatic ref_div(input logic [15:0] a, input logic [7:0] b,
                         output logic [15:0] q, output logic [7:0] r, output logic z);
    if (b == 8'd0) begin
      q = 16'hFFFF;
      r = a[7:0];
      z = 1'b1;
    end else begin
      q = a / {8'd0, b};
      r = 8'(a % {8'd0, b});
      z = 1'b0;
    end
  endtask

  // Wait (bounded) for in_ready, present a request and return #1 after the
  // accepting edge with in_valid dropped and the operand pins scrambled.
  task automatic send(input logic [15:0] a, input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 64) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_before_send", {31'd0, in_ready}, 32'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask

  // Count edges from the accepting edge until out_valid is seen.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_one(input logic [15:0] a, input logic [7:0] b,
                         input logic [15:0] eq, input logic [7:0] er, input logic ez);
    int lat;
    send(a, b);
    wait_result(lat);
    check("latency", lat, 32'd16);
    check("out_valid", {31'd0, out_valid}, 32'd1);
    check("quotient", {16'd0, quotient}, {16'd0, eq});
    check("remainder", {24'd0, remainder}, {24'd0, er});
    check("div_by_zero", {31'd0, div_by_zero}, {31'd0, ez});
    @(posedge clk);
    #1;
    check("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
    check("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [15:0] q, p;
    logic [7:0]  r, aa, bb;
    logic        z;
    int lat, busy, seen, max_err, e;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;

    vecs.push_back('{16'd1000,  8'd7,   16'd142,   8'd6,    1'b0});
    vecs.push_back('{16'hFFFF,  8'd1,   16'hFFFF,  8'd0,    1'b0});
    vecs.push_back('{16'hFFFF,  8'hFF,  16'd257,   8'd0,    1'b0});
    vecs.push_back('{16'h1234,  8'd0,   16'hFFFF,  8'h34,   1'b1});
    vecs.push_back('{16'd200,   8'd9,   16'd22,    8'd2,    1'b0});
    vecs.push_back('{16'd0,     8'd5,   16'd0,     8'd0,    1'b0});
    vecs.push_back('{16'd5,     8'd10,  16'd0,     8'd5,    1'b0});
    vecs.push_back('{16'd0,     8'd0,   16'hFFFF,  8'd0,    1'b1});
    vecs.push_back('{16'd65535, 8'd254, 16'd258,   8'd3,    1'b0});

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_quotient", {16'd0, quotient}, 32'd0);
    check("rst_remainder", {24'd0, remainder}, 32'd0);
    check("rst_div_by_zero", {31'd0, div_by_zero}, 32'd0);

    // Directed vectors.
    foreach (vecs[i]) run_one(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z);

    // Backpressure, with a new request held pending during RUN and DONE.
    out_ready = 1'b0;
    send(16'd50000, 8'd123);
    in_valid = 1'b1;
    dividend = 16'h1234;
    divisor  = 8'd0;
    lat  = 0;
    busy = 0;
    while (!out_valid && lat < 64) begin
      if (in_ready) busy++;
      @(posedge clk);
      #1;
      lat++;
    end
    check("bp_in_ready_run", busy, 32'd0);
    check("bp_latency", lat, 32'd16);
    for (int k = 0; k < 5; k++) begin
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready_done", {31'd0, in_ready}, 32'd0);
      check("bp_quotient", {16'd0, quotient}, 32'd406);
      check("bp_remainder", {24'd0, remainder}, 32'd62);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_hs_out_valid", {31'd0, out_valid}, 32'd0);
    check("bp_hs_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    check("pending_accepted", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    wait_result(lat);
    check("pending_latency", lat, 32'd16);
    check("pending_quotient", {16'd0, quotient}, 32'h0000FFFF);
    check("pending_remainder", {24'd0, remainder}, 32'h34);
    check("pending_div_by_zero", {31'd0, div_by_zero}, 32'd1);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a division.
    send(16'd1000, 8'd3);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_quotient", {16'd0, quotient}, 32'd0);
    check("midrst_remainder", {24'd0, remainder}, 32'd0);
    check("midrst_div_by_zero", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("midrst_no_result", seen, 32'd0);
    run_one(16'd200, 8'd9, 16'd22, 8'd2, 1'b0);

    // Random exact products: P / A must give B with no remainder.
    for (int i = 0; i < 300; i++) begin
      aa = 8'($urandom_range(1, 255));
      bb = 8'($urandom_range(1, 255));
      p  = {8'd0, aa} * {8'd0, bb};
      run_one(p, aa, {8'd0, bb}, 8'd0, 1'b0);
    end

    // Random operands, occasionally a zero divisor.
    for (int i = 0; i < 150; i++) begin
      p  = 16'($urandom);
      aa = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      ref_div(p, aa, q, r, z);
      run_one(p, aa, q, r, z);
    end

    // Approximate products (low nibble truncated): log how far B drifts.
    max_err = 0;
    for (int i = 0; i < 50; i++) begin
      aa = 8'($urandom_range(1, 255));
      bb = 8'($urandom_range(1, 255));
      p  = ({8'd0, aa} * {8'd0, bb}) & 16'hFFF0;
      ref_div(p, aa, q, r, z);
      run_one(p, aa, q, r, z);
      e = int'(quotient) - int'(bb);
      if (e < 0) e = -e;
      if (e > max_err) max_err = e;
    end
    $display("approximate product: max |quotient-B| = %0d", max_err);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
